stack_seq: RTL and testbench
============================

# stack_seq

Push/pull sequencer for the MC6809 PSHS/PSHU/PULS/PULU instructions and interrupt state stacking. It is the initiator towards the register block: it reads registers over one read path, steps the active stack pointer with `inc_su`/`dec_su`, and writes pulled values back through the register write port. It also drives a byte-wide memory port. The CPU control FSM starts it with a postbyte register mask and waits for `done`.

## Interface
Parameters:
- none

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: synchronous, active-high reset.
- `start` in 1: begin an operation. Sampled only in IDLE.
- `is_pull` in 1: 0 = push, 1 = pull. Sampled with `start`.
- `use_s_in` in 1: 1 = S is the active stack, 0 = U. Sampled with `start`.
- `postbyte` in 8: register mask. b7 PC, b6 other stack pointer, b5 Y, b4 X, b3 DP, b2 B, b1 A, b0 CC.
- `reg_su` in 16: active stack pointer value from the register block.
- `path_left_data` in 16: register read data.
- `ccr_in` in 8: current CC, read directly.
- `mem_data_i` in 8: memory read data, valid the cycle after `mem_re`.
- `path_left_addr` out 4: register read select. Encoding is shared with write codes: 1 X, 2 Y, 3 U, 4 S, 5 PC, 8 A, 9 B, 11 DP.
- `write_reg` out 1: register write strobe.
- `write_reg_addr` out 4: register write select. Same codes as `path_left_addr`; 10 = CC.
- `data_w` out 16: register write data.
- `inc_su` out 1: stack pointer increment strobe.
- `dec_su` out 1: stack pointer decrement strobe.
- `use_s` out 1: latched stack select, fed to the register block.
- `mem_addr` out 16: memory address.
- `mem_data_o` out 8: memory write data.
- `mem_we` out 1: memory write strobe.
- `mem_re` out 1: memory read strobe.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.

## Operation
- Mask, direction and stack select are latched on `start`. The "other stack" is U (code 3) when `use_s` = 1, otherwise S (code 4).
- Push byte order: PCL, PCH, otherL, otherH, YL, YH, XL, XH, DP, B, A, CC. Unselected registers are skipped.
- Pull byte order is the exact reverse: CC, A, B, DP, XH, XL, YH, YL, otherH, otherL, PCH, PCL.
- FSM states: IDLE, DEC, WR, RD, CAP, DONE.
- IDLE:
  - `start` with push and a nonzero mask goes to DEC.
  - `start` with pull and a nonzero mask goes to RD.
  - `start` with a zero mask goes to DONE.
- DEC: `dec_su` = 1, then go to WR.
- WR:
  - `mem_addr` = `reg_su` (already decremented), `mem_we` = 1.
  - `mem_data_o` = selected byte of `path_left_data`, or `ccr_in` for CC.
  - Next state is DEC if bytes remain, else DONE.
- RD: `mem_addr` = `reg_su`, `mem_re` = 1, then go to CAP.
- CAP: `inc_su` = 1.
  - 8-bit register: `write_reg` = 1, `data_w` = {8'h00, `mem_data_i`}.
  - High byte of a 16-bit register: latch it into `hi_q`, no write.
  - Low byte: `write_reg` = 1, `data_w` = {`hi_q`, `mem_data_i`}.
  - Next state is RD if bytes remain, else DONE.
- DONE: `done` = 1, then go to IDLE.
- The sequencer never writes the active stack pointer. PC is pulled through `write_reg` code 5, so the control FSM must hold `inc_pc` and `write_pc` low while `busy`.
- `start` is ignored while `busy`.

## Timing
- Reset values: all strobes 0, `busy` = 0, `done` = 0, `mem_addr` = 0, `data_w` = 0, `use_s` = 0, `hi_q` = 0, state = IDLE.
- Push of n bytes: `done` is high in cycle 2n+1 after the `start` cycle.
- Pull of n bytes: `done` is high in cycle 2n+1 after the `start` cycle.
- Zero mask: `done` is high in cycle 1.
- A full-mask push or pull (12 bytes) has `done` in cycle 25.
- Stack pointer arithmetic wraps modulo 2^16 in the register block; no special handling here.
- `rst_in` mid-operation returns to IDLE on the next edge with no further strobes. The stack pointer keeps any steps already taken.

## Configuration
- `STACK_SEQ_BYTECOUNT_EN` defined: adds output `byte_count` [3:0].
  - Cleared on an accepted `start`.
  - Increments once per WR or CAP cycle.
  - Holds after `done`.
  - Resets to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- PSHS, mask 0x86, S = 0x0F00, PC = 0x1234, A = 0x11, B = 0x22 -> writes 0x0EFF=34, 0x0EFE=12, 0x0EFD=22, 0x0EFC=11; S ends at 0x0EFC; `done` in cycle 9.
- PULS, mask 0x86, from the memory image above -> `write_reg` code 8 with 0x0011, code 9 with 0x0022, code 5 with 0x1234; S ends at 0x0F00; `done` in cycle 9.
- PSHU, mask 0x40, U = 0x0E00, S = 0xBEEF -> 0x0DFF=EF, 0x0DFE=BE; U ends at 0x0DFE; S unchanged.
- Zero mask -> `done` in cycle 1, no strobes; with `STACK_SEQ_BYTECOUNT_EN`, `byte_count` = 0.
- Full-mask push then pull -> all registers restored, SP restored, `done` in cycle 25 each; with `STACK_SEQ_BYTECOUNT_EN`, `byte_count` = 12.
- `rst_in` in cycle 3 of a PSHS with mask 0xFF, plus a second `start` while `busy` -> IDLE with all strobes low after reset; the second `start` is ignored.

Source files
------------

// File: rtl/stack_seq.sv
// Push/pull sequencer for MC6809 PSHS/PSHU/PULS/PULU and interrupt stacking.
// Optional STACK_SEQ_BYTECOUNT_EN adds a byte_count output.
module stack_seq (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start,
    input  logic        is_pull,
    input  logic        use_s_in,
    input  logic [7:0]  postbyte,
    input  logic [15:0] reg_su,
    input  logic [15:0] path_left_data,
    input  logic [7:0]  ccr_in,
    input  logic [7:0]  mem_data_i,
    output logic [3:0]  path_left_addr,
    output logic        write_reg,
    output logic [3:0]  write_reg_addr,
    output logic [15:0] data_w,
    output logic        inc_su,
    output logic        dec_su,
    output logic        use_s,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_o,
    output logic        mem_we,
    output logic        mem_re,
    output logic        busy,
    output logic        done
`ifdef STACK_SEQ_BYTECOUNT_EN
    ,
    output logic [3:0]  byte_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DEC  = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_CAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic        pull_r, use_s_r, busy_r, done_r;
    logic [11:0] rem_r, rem_next_s;
    logic [7:0]  hi_q_r;
    logic [3:0]  slot_s, code_s;
    logic        more_s, hi_byte_s, byte8_s, accept_s;

    // Slot k is the k-th byte in push order: PCL,PCH,oL,oH,YL,YH,XL,XH,DP,B,A,CC.
    function automatic logic [11:0] expand_mask(input logic [7:0] m);
        return {m[0], m[1], m[2], m[3], m[4], m[4], m[5], m[5], m[6], m[6], m[7], m[7]};
    endfunction

    // Push takes the lowest pending slot, pull the highest.
    function automatic logic [3:0] pick_slot(input logic [11:0] rem, input logic from_top);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (from_top) idx = rem[i] ? 4'(i) : idx;
            else          idx = rem[11 - i] ? 4'(11 - i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [3:0] slot_code(input logic [3:0] slot, input logic sel_s);
        case (slot)
            4'd0, 4'd1: return 4'd5;
            4'd2, 4'd3: return sel_s ? 4'd3 : 4'd4;
            4'd4, 4'd5: return 4'd2;
            4'd6, 4'd7: return 4'd1;
            4'd8:       return 4'd11;
            4'd9:       return 4'd9;
            4'd10:      return 4'd8;
            4'd11:      return 4'd10;
            default:    return 4'd0;
        endcase
    endfunction

    assign accept_s   = (state_r == S_IDLE) && start;
    assign slot_s     = pick_slot(rem_r, pull_r);
    assign rem_next_s = rem_r & ~(12'd1 << slot_s);
    assign more_s     = |rem_next_s;
    assign code_s     = slot_code(slot_s, use_s_r);
    assign hi_byte_s  = (slot_s < 4'd8) && slot_s[0];
    assign byte8_s    = (slot_s >= 4'd8);

    // Next-state and strobe decode.
    always_comb begin
        state_s        = state_r;
        path_left_addr = 4'd0;
        write_reg      = 1'b0;
        write_reg_addr = 4'd0;
        data_w         = 16'h0000;
        inc_su         = 1'b0;
        dec_su         = 1'b0;
        mem_addr       = 16'h0000;
        mem_data_o     = 8'h00;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (postbyte == 8'h00) state_s = S_DONE;
                    else if (is_pull)      state_s = S_RD;
                    else                   state_s = S_DEC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DEC: begin
                dec_su         = 1'b1;
                path_left_addr = code_s;
                state_s        = S_WR;
            end
            S_WR: begin
                mem_addr       = reg_su;
                mem_we         = 1'b1;
                path_left_addr = code_s;
                if (slot_s == 4'd11)  mem_data_o = ccr_in;
                else if (hi_byte_s)   mem_data_o = path_left_data[15:8];
                else                  mem_data_o = path_left_data[7:0];
                state_s = more_s ? S_DEC : S_DONE;
            end
            S_RD: begin
                mem_addr = reg_su;
                mem_re   = 1'b1;
                state_s  = S_CAP;
            end
            S_CAP: begin
                inc_su = 1'b1;
                // High byte of a pair waits in hi_q_r for its low byte.
                if (hi_byte_s) begin
                    write_reg = 1'b0;
                end else begin
                    write_reg      = 1'b1;
                    write_reg_addr = code_s;
                    data_w         = byte8_s ? {8'h00, mem_data_i} : {hi_q_r, mem_data_i};
                end
                state_s = more_s ? S_RD : S_DONE;
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, latched operands and status registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= S_IDLE;
            pull_r  <= 1'b0;
            use_s_r <= 1'b0;
            rem_r   <= 12'h000;
            hi_q_r  <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != S_IDLE);
            done_r  <= (state_s == S_DONE);
            if (accept_s) begin
                pull_r  <= is_pull;
                use_s_r <= use_s_in;
                rem_r   <= expand_mask(postbyte);
            end else if ((state_r == S_WR) || (state_r == S_CAP)) begin
                rem_r <= rem_next_s;
            end
            if ((state_r == S_CAP) && hi_byte_s) begin
                hi_q_r <= mem_data_i;
            end
        end
    end

    assign use_s = use_s_r;
    assign busy  = busy_r;
    assign done  = done_r;

`ifdef STACK_SEQ_BYTECOUNT_EN
    logic [3:0] byte_count_r;

    // Bytes transferred by the current or most recent operation.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            byte_count_r <= 4'd0;
        end else if (accept_s) begin
            byte_count_r <= 4'd0;
        end else if ((state_r == S_WR) || (state_r == S_CAP)) begin
            byte_count_r <= byte_count_r + 4'd1;
        end
    end

    assign byte_count = byte_count_r;
`endif

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: register-block/memory model plus
// scoreboard queues of expected memory writes, memory reads and register writes.
module tb_stack_seq;

    logic        clk_in = 1'b0;
    logic        rst_in, start, is_pull, use_s_in;
    logic [7:0]  postbyte, ccr_in, mem_data_i, mem_data_o;
    logic [15:0] reg_su, path_left_data, data_w, mem_addr;
    logic [3:0]  path_left_addr, write_reg_addr;
    logic        write_reg, inc_su, dec_su, use_s, mem_we, mem_re, busy, done;
`ifdef STACK_SEQ_BYTECOUNT_EN
    logic [3:0]  byte_count;
`endif

    always #5 clk_in = ~clk_in;

    stack_seq dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .is_pull(is_pull),
        .use_s_in(use_s_in), .postbyte(postbyte), .reg_su(reg_su),
        .path_left_data(path_left_data), .ccr_in(ccr_in), .mem_data_i(mem_data_i),
        .path_left_addr(path_left_addr), .write_reg(write_reg),
        .write_reg_addr(write_reg_addr), .data_w(data_w), .inc_su(inc_su),
        .dec_su(dec_su), .use_s(use_s), .mem_addr(mem_addr), .mem_data_o(mem_data_o),
        .mem_we(mem_we), .mem_re(mem_re), .busy(busy), .done(done)
`ifdef STACK_SEQ_BYTECOUNT_EN
        , .byte_count(byte_count)
`endif
    );

    // ---------------- register block and memory model ----------------
    logic [15:0] rx, ry, ru, rs, rpc;
    logic [7:0]  ra, rb, rdp, rcc;
    logic [7:0]  mem [0:65535];
    logic        ld_en = 1'b0;
    logic [15:0] ld_x, ld_y, ld_u, ld_s, ld_pc;
    logic [7:0]  ld_a, ld_b, ld_dp, ld_cc;

    assign reg_su = use_s ? rs : ru;
    assign ccr_in = rcc;

    always_comb begin
        case (path_left_addr)
            4'd1:    path_left_data = rx;
            4'd2:    path_left_data = ry;
            4'd3:    path_left_data = ru;
            4'd4:    path_left_data = rs;
            4'd5:    path_left_data = rpc;
            4'd8:    path_left_data = {8'h00, ra};
            4'd9:    path_left_data = {8'h00, rb};
            4'd11:   path_left_data = {8'h00, rdp};
            default: path_left_data = 16'h0000;
        endcase
    end

    always @(posedge clk_in) begin
        if (ld_en) begin
            rx <= ld_x; ry <= ld_y; ru <= ld_u; rs <= ld_s; rpc <= ld_pc;
            ra <= ld_a; rb <= ld_b; rdp <= ld_dp; rcc <= ld_cc;
        end else begin
            if (write_reg) begin
                case (write_reg_addr)
                    4'd1:  rx  <= data_w;
                    4'd2:  ry  <= data_w;
                    4'd3:  ru  <= data_w;
                    4'd4:  rs  <= data_w;
                    4'd5:  rpc <= data_w;
                    4'd8:  ra  <= data_w[7:0];
                    4'd9:  rb  <= data_w[7:0];
                    4'd10: rcc <= data_w[7:0];
                    4'd11: rdp <= data_w[7:0];
                    default: ;
                endcase
            end
            if (dec_su) begin
                if (use_s) rs <= rs - 16'd1;
                else       ru <= ru - 16'd1;
            end
            if (inc_su) begin
                if (use_s) rs <= rs + 16'd1;
                else       ru <= ru + 16'd1;
            end
        end
        if (mem_we) mem[mem_addr] <= mem_data_o;
        if (mem_re) mem_data_i <= mem[mem_addr];
    end

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [15:0] addr; logic [7:0] data; } memw_t;
    typedef struct packed { logic [3:0] code; logic [15:0] data; } regw_t;
    memw_t       exp_mw[$];
    logic [15:0] exp_rd[$];
    regw_t       exp_rw[$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [6:0]  strb;

    assign strb = {mem_we, mem_re, write_reg, inc_su, dec_su, done, busy};

    task automatic exp_write(input logic [15:0] a, input logic [7:0] d);
        memw_t e;
        e.addr = a; e.data = d;
        exp_mw.push_back(e);
    endtask

    task automatic exp_reg(input logic [3:0] c, input logic [15:0] d);
        regw_t e;
        e.code = c; e.data = d;
        exp_rw.push_back(e);
    endtask

    task automatic set_regs(input logic [15:0] x, y, u, s, pc, input logic [7:0] a, b, dp, cc);
        @(negedge clk_in);
        ld_x = x; ld_y = y; ld_u = u; ld_s = s; ld_pc = pc;
        ld_a = a; ld_b = b; ld_dp = dp; ld_cc = cc;
        ld_en = 1'b1;
        @(negedge clk_in);
        ld_en = 1'b0;
    endtask

    // Starts one operation, scores every strobe against the queues, returns the done cycle.
    task automatic run_op(input logic pull, input logic sel_s, input logic [7:0] mask,
                          output int done_cyc);
        memw_t mw;
        regw_t rw;
        logic [15:0] ra_exp;
        @(negedge clk_in);
        start = 1'b1; is_pull = pull; use_s_in = sel_s; postbyte = mask;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk_in);
            start = 1'b0;
            if (mem_we === 1'b1) begin
                n_vec++;
                if (exp_mw.size() == 0) begin
                    n_miss++;
                    $display("FAIL mem_write: unexpected write %h=%h", mem_addr, mem_data_o);
                end else begin
                    mw = exp_mw.pop_front();
                    if ({mem_addr, mem_data_o} !== {mw.addr, mw.data}) begin
                        n_miss++;
                        $display("FAIL mem_write: got %h=%h, expected %h=%h",
                                 mem_addr, mem_data_o, mw.addr, mw.data);
                    end
                end
            end
            if (mem_re === 1'b1) begin
                n_vec++;
                if (exp_rd.size() == 0) begin
                    n_miss++;
                    $display("FAIL mem_read: unexpected read at %h", mem_addr);
                end else begin
                    ra_exp = exp_rd.pop_front();
                    if (mem_addr !== ra_exp) begin
                        n_miss++;
                        $display("FAIL mem_read: got addr %h, expected %h", mem_addr, ra_exp);
                    end
                end
            end
            if (write_reg === 1'b1) begin
                n_vec++;
                if (exp_rw.size() == 0) begin
                    n_miss++;
                    $display("FAIL reg_write: unexpected code %0d data %h", write_reg_addr, data_w);
                end else begin
                    rw = exp_rw.pop_front();
                    if ({write_reg_addr, data_w} !== {rw.code, rw.data}) begin
                        n_miss++;
                        $display("FAIL reg_write: got code %0d data %h, expected code %0d data %h",
                                 write_reg_addr, data_w, rw.code, rw.data);
                    end
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        n_vec++;
        if ((exp_mw.size() + exp_rd.size() + exp_rw.size()) != 0) begin
            n_miss++;
            $display("FAIL leftover: %0d writes, %0d reads, %0d reg writes still expected",
                     exp_mw.size(), exp_rd.size(), exp_rw.size());
            exp_mw.delete(); exp_rd.delete(); exp_rw.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_vec++;
        if ({strb, use_s} !== 8'h00) begin
            n_miss++;
            $display("FAIL reset_strobes: got %b, expected 00000000", {strb, use_s});
        end
        n_vec++;
        if ({mem_addr, data_w} !== 32'h0000_0000) begin
            n_miss++;
            $display("FAIL reset_buses: got %h, expected 00000000", {mem_addr, data_w});
        end
        rst_in = 1'b0;
    endtask

    task automatic test_pshs;
        int dc;
        set_regs(16'h0000, 16'h0000, 16'h0E00, 16'h0F00, 16'h1234, 8'h11, 8'h22, 8'h00, 8'h00);
        exp_write(16'h0EFF, 8'h34); exp_write(16'h0EFE, 8'h12);
        exp_write(16'h0EFD, 8'h22); exp_write(16'h0EFC, 8'h11);
        run_op(1'b0, 1'b1, 8'h86, dc);
        n_vec++;
        if (dc !== 9) begin n_miss++; $display("FAIL pshs_done: got cycle %0d, expected 9", dc); end
        @(negedge clk_in);
        n_vec++;
        if (rs !== 16'h0EFC) begin n_miss++; $display("FAIL pshs_sp: got %h, expected 0efc", rs); end
    endtask

    task automatic test_puls;
        int dc;
        set_regs(16'h0000, 16'h0000, 16'h0E00, 16'h0EFC, 16'hFFFF, 8'hAA, 8'hBB, 8'h00, 8'h00);
        exp_rd.push_back(16'h0EFC); exp_rd.push_back(16'h0EFD);
        exp_rd.push_back(16'h0EFE); exp_rd.push_back(16'h0EFF);
        exp_reg(4'd8, 16'h0011); exp_reg(4'd9, 16'h0022); exp_reg(4'd5, 16'h1234);
        run_op(1'b1, 1'b1, 8'h86, dc);
        n_vec++;
        if (dc !== 9) begin n_miss++; $display("FAIL puls_done: got cycle %0d, expected 9", dc); end
        @(negedge clk_in);
        n_vec++;
        if ({rs, rpc, ra, rb} !== 48'h0F00_1234_11_22) begin
            n_miss++;
            $display("FAIL puls_regs: got %h, expected 0f00123411 22", {rs, rpc, ra, rb});
        end
    endtask

    task automatic test_pshu_pulu;
        int dc;
        set_regs(16'h0000, 16'h0000, 16'h0E00, 16'hBEEF, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);
        exp_write(16'h0DFF, 8'hEF); exp_write(16'h0DFE, 8'hBE);
        run_op(1'b0, 1'b0, 8'h40, dc);
        n_vec++;
        if (dc !== 5) begin n_miss++; $display("FAIL pshu_done: got cycle %0d, expected 5", dc); end
        @(negedge clk_in);
        n_vec++;
        if ({ru, rs} !== 32'h0DFE_BEEF) begin
            n_miss++;
            $display("FAIL pshu_sp: got %h, expected 0dfebeef", {ru, rs});
        end
        set_regs(16'h0000, 16'h0000, 16'h0DFE, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);
        exp_rd.push_back(16'h0DFE); exp_rd.push_back(16'h0DFF);
        exp_reg(4'd4, 16'hBEEF);
        run_op(1'b1, 1'b0, 8'h40, dc);
        n_vec++;
        if (dc !== 5) begin n_miss++; $display("FAIL pulu_done: got cycle %0d, expected 5", dc); end
        @(negedge clk_in);
        n_vec++;
        if ({ru, rs} !== 32'h0E00_BEEF) begin
            n_miss++;
            $display("FAIL pulu_regs: got %h, expected 0e00beef", {ru, rs});
        end
    endtask

    task automatic test_zero_mask;
        int dc;
        run_op(1'b0, 1'b1, 8'h00, dc);
        n_vec++;
        if (dc !== 1) begin n_miss++; $display("FAIL zero_done: got cycle %0d, expected 1", dc); end
`ifdef STACK_SEQ_BYTECOUNT_EN
        n_vec++;
        if (byte_count !== 4'd0) begin
            n_miss++;
            $display("FAIL zero_count: got %0d, expected 0", byte_count);
        end
`endif
    endtask

    task automatic test_full_mask;
        int dc;
        logic [7:0] pb [12];
        pb = '{8'hD2, 8'hD1, 8'hC2, 8'hC1, 8'hB2, 8'hB1, 8'hA2, 8'hA1, 8'hE3, 8'hE2, 8'hE1, 8'hE4};
        set_regs(16'hA1A2, 16'hB1B2, 16'hC1C2, 16'h2000, 16'hD1D2, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
        for (int i = 0; i < 12; i++) exp_write(16'h1FFF - 16'(i), pb[i]);
        run_op(1'b0, 1'b1, 8'hFF, dc);
        n_vec++;
        if (dc !== 25) begin n_miss++; $display("FAIL full_push_done: got cycle %0d, expected 25", dc); end
`ifdef STACK_SEQ_BYTECOUNT_EN
        n_vec++;
        if (byte_count !== 4'd12) begin
            n_miss++;
            $display("FAIL full_push_count: got %0d, expected 12", byte_count);
        end
`endif
        @(negedge clk_in);
        n_vec++;
        if (rs !== 16'h1FF4) begin n_miss++; $display("FAIL full_push_sp: got %h, expected 1ff4", rs); end
        set_regs(16'h0000, 16'h0000, 16'h0000, 16'h1FF4, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) exp_rd.push_back(16'h1FF4 + 16'(i));
        exp_reg(4'd10, 16'h00E4); exp_reg(4'd8, 16'h00E1); exp_reg(4'd9, 16'h00E2);
        exp_reg(4'd11, 16'h00E3); exp_reg(4'd1, 16'hA1A2); exp_reg(4'd2, 16'hB1B2);
        exp_reg(4'd3, 16'hC1C2); exp_reg(4'd5, 16'hD1D2);
        run_op(1'b1, 1'b1, 8'hFF, dc);
        n_vec++;
        if (dc !== 25) begin n_miss++; $display("FAIL full_pull_done: got cycle %0d, expected 25", dc); end
`ifdef STACK_SEQ_BYTECOUNT_EN
        n_vec++;
        if (byte_count !== 4'd12) begin
            n_miss++;
            $display("FAIL full_pull_count: got %0d, expected 12", byte_count);
        end
`endif
        @(negedge clk_in);
        n_vec++;
        if ({rx, ry, ru, rs, rpc, ra, rb, rdp, rcc} !==
            {16'hA1A2, 16'hB1B2, 16'hC1C2, 16'h2000, 16'hD1D2, 8'hE1, 8'hE2, 8'hE3, 8'hE4}) begin
            n_miss++;
            $display("FAIL full_restore: got %h", {rx, ry, ru, rs, rpc, ra, rb, rdp, rcc});
        end
    endtask

    task automatic test_reset_midop;
        set_regs(16'h0000, 16'h0000, 16'h0100, 16'h3000, 16'h5678, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk_in);
        start = 1'b1; is_pull = 1'b0; use_s_in = 1'b1; postbyte = 8'hFF;
        @(negedge clk_in);
        start = 1'b0;
        n_vec++;
        if ({dec_su, busy} !== 2'b11) begin
            n_miss++;
            $display("FAIL midop_c1: got dec_su/busy %b, expected 11", {dec_su, busy});
        end
        @(negedge clk_in);
        n_vec++;
        if ({mem_we, mem_addr, mem_data_o} !== {1'b1, 16'h2FFF, 8'h78}) begin
            n_miss++;
            $display("FAIL midop_c2: got %b %h=%h, expected 1 2fff=78", mem_we, mem_addr, mem_data_o);
        end
        start = 1'b1; is_pull = 1'b1; postbyte = 8'h01;
        @(negedge clk_in);
        start = 1'b0;
        n_vec++;
        if ({dec_su, mem_re} !== 2'b10) begin
            n_miss++;
            $display("FAIL midop_c3: got dec_su/mem_re %b, expected 10", {dec_su, mem_re});
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (strb !== 7'b0000000) begin
                n_miss++;
                $display("FAIL midop_idle: cycle %0d after reset strobes %b, expected 0000000", k, strb);
            end
            @(negedge clk_in);
        end
        n_vec++;
        if (rs !== 16'h2FFE) begin n_miss++; $display("FAIL midop_sp: got %h, expected 2ffe", rs); end
    endtask

    initial begin
        start = 1'b0; is_pull = 1'b0; use_s_in = 1'b0; postbyte = 8'h00; rst_in = 1'b1;
        test_reset;
        test_pshs;
        test_puls;
        test_pshu_pulu;
        test_zero_mask;
        test_full_mask;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
